// File: rtl/axi4_burst_sram_slave.sv
// ---------------------------------------------------------------------------
// axi4_burst_sram_slave
//   AXI4 subordinate in front of an on-chip word-addressed SRAM array.
//   Supports INCR and FIXED bursts of 1-256 beats, byte-strobed writes and
//   per-beat read responses. Beats outside the address window, and bursts
//   with an unsupported BURST/SIZE encoding, are answered with SLVERR.
//   Read and write paths are independent FSMs, one outstanding burst each.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   S_AXI_AW*             write address channel (ADDR, LEN, SIZE, BURST,
//                         VALID in; READY out)
//   S_AXI_W*              write data channel (DATA, STRB, LAST, VALID in;
//                         READY out)
//   S_AXI_B*              write response channel (RESP, VALID out; READY in)
//   S_AXI_AR*             read address channel (ADDR, LEN, SIZE, BURST,
//                         VALID in; READY out)
//   S_AXI_R*              read data channel (DATA, RESP, LAST, VALID out;
//                         READY in)
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module axi4_burst_sram_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // write address
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  // write data
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  // write response
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  // read address
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [2:0]              S_AXI_ARSIZE,
  input  logic [1:0]              S_AXI_ARBURST,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  // read data
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int                    IDX_W       = $clog2(MEM_DEPTH);
  localparam int                    STRB_W      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES   = ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;
  localparam logic [1:0]            BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Unsigned subtraction makes addresses below BASE_ADDR wrap to a huge
  // offset, so one compare covers both ends of the window.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offset;
    offset = addr - BASE_ADDR;
    return (offset < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offset;
    offset = addr - BASE_ADDR;
    return IDX_W'(offset >> 2);
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    return (burst[1] == 1'b1) || (size > 3'd2);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
    if (burst == BURST_INCR) begin
      return addr + (ADDR_ONE << size);
    end else begin
      return addr;
    end
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // ---------------------------------------------------------------- write --
  w_state_t              r_w_state, w_w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
  logic [7:0]            r_awlen, w_awlen_nxt;
  logic [2:0]            r_awsize, w_awsize_nxt;
  logic [1:0]            r_awburst, w_awburst_nxt;
  logic [7:0]            r_wbeat, w_wbeat_nxt;
  logic                  r_werr, w_werr_nxt;
  logic                  r_awready, w_awready_nxt;
  logic                  r_wready, w_wready_nxt;
  logic                  r_bvalid, w_bvalid_nxt;
  logic [1:0]            r_bresp, w_bresp_nxt;

  logic                  w_wfire;
  logic                  w_mem_we;
  logic                  w_werr_beat;
  logic                  w_wend_beat;
  logic [IDX_W-1:0]      w_widx;

  assign w_wfire     = (r_w_state == W_DATA) && S_AXI_WVALID && r_wready;
  assign w_mem_we    = w_wfire && !burst_err(r_awsize, r_awburst) && in_range(r_awaddr);
  assign w_widx      = word_idx(r_awaddr);
  // A WLAST that disagrees with the beat count poisons the response.
  assign w_werr_beat = r_werr || !w_mem_we || ((r_wbeat == r_awlen) != S_AXI_WLAST);
  // The burst ends on whichever comes first: the counted last beat or WLAST.
  assign w_wend_beat = (r_wbeat == r_awlen) || S_AXI_WLAST;

  // Write FSM next-state and next-output logic.
  always_comb begin
    w_w_state_nxt = r_w_state;
    w_awaddr_nxt  = r_awaddr;
    w_awlen_nxt   = r_awlen;
    w_awsize_nxt  = r_awsize;
    w_awburst_nxt = r_awburst;
    w_wbeat_nxt   = r_wbeat;
    w_werr_nxt    = r_werr;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    case (r_w_state)
      W_IDLE: begin
        if (S_AXI_AWVALID && r_awready) begin
          w_awaddr_nxt  = S_AXI_AWADDR;
          w_awlen_nxt   = S_AXI_AWLEN;
          w_awsize_nxt  = S_AXI_AWSIZE;
          w_awburst_nxt = S_AXI_AWBURST;
          w_wbeat_nxt   = 8'd0;
          w_werr_nxt    = 1'b0;
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b1;
          w_w_state_nxt = W_DATA;
        end else begin
          w_awready_nxt = 1'b1;
        end
      end
      W_DATA: begin
        if (w_wfire) begin
          w_werr_nxt   = w_werr_beat;
          w_awaddr_nxt = next_addr(r_awaddr, r_awsize, r_awburst);
          w_wbeat_nxt  = r_wbeat + 8'd1;
          if (w_wend_beat) begin
            w_wready_nxt  = 1'b0;
            w_bvalid_nxt  = 1'b1;
            w_bresp_nxt   = w_werr_beat ? RESP_SLVERR : RESP_OKAY;
            w_w_state_nxt = W_RESP;
          end else begin
            w_w_state_nxt = W_DATA;
          end
        end else begin
          w_w_state_nxt = W_DATA;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY && r_bvalid) begin
          w_bvalid_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_w_state_nxt = W_IDLE;
        end else begin
          w_w_state_nxt = W_RESP;
        end
      end
      default: begin
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b0;
        w_bvalid_nxt  = 1'b0;
        w_w_state_nxt = W_IDLE;
      end
    endcase
  end

  // Write FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_state <= W_IDLE;
      r_awaddr  <= {ADDR_WIDTH{1'b0}};
      r_awlen   <= 8'd0;
      r_awsize  <= 3'd0;
      r_awburst <= 2'b00;
      r_wbeat   <= 8'd0;
      r_werr    <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_w_state <= w_w_state_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_awlen   <= w_awlen_nxt;
      r_awsize  <= w_awsize_nxt;
      r_awburst <= w_awburst_nxt;
      r_wbeat   <= w_wbeat_nxt;
      r_werr    <= w_werr_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // Byte-lane write into the array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (S_AXI_WSTRB[i]) begin
          r_mem[w_widx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read --
  r_state_t              r_r_state, w_r_state_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
  logic [7:0]            r_arlen, w_arlen_nxt;
  logic [2:0]            r_arsize, w_arsize_nxt;
  logic [1:0]            r_arburst, w_arburst_nxt;
  logic [7:0]            r_rbeat, w_rbeat_nxt;
  logic                  r_arready, w_arready_nxt;
  logic                  r_rvalid, w_rvalid_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic [1:0]            r_rresp, w_rresp_nxt;
  logic                  r_rlast, w_rlast_nxt;

  logic                  w_arfire;
  logic                  w_rfire;
  logic [ADDR_WIDTH-1:0] w_ra_next;
  logic [ADDR_WIDTH-1:0] w_rl_addr;
  logic                  w_rl_ok;
  logic [DATA_WIDTH-1:0] w_rl_data;

  assign w_arfire  = (r_r_state == R_IDLE) && S_AXI_ARVALID && r_arready;
  assign w_rfire   = (r_r_state == R_DATA) && r_rvalid && S_AXI_RREADY;
  assign w_ra_next = next_addr(r_araddr, r_arsize, r_arburst);
  // One lookup port serves both the first beat (from the AR channel) and
  // every following beat (from the advanced burst address). Reading the
  // array here sees the value from before any same-edge write.
  assign w_rl_addr = w_arfire ? S_AXI_ARADDR : w_ra_next;
  assign w_rl_ok   = (w_arfire ? !burst_err(S_AXI_ARSIZE, S_AXI_ARBURST)
                               : !burst_err(r_arsize, r_arburst)) && in_range(w_rl_addr);
  assign w_rl_data = w_rl_ok ? r_mem[word_idx(w_rl_addr)] : {DATA_WIDTH{1'b0}};

  // Read FSM next-state and next-output logic.
  always_comb begin
    w_r_state_nxt = r_r_state;
    w_araddr_nxt  = r_araddr;
    w_arlen_nxt   = r_arlen;
    w_arsize_nxt  = r_arsize;
    w_arburst_nxt = r_arburst;
    w_rbeat_nxt   = r_rbeat;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    w_rlast_nxt   = r_rlast;
    case (r_r_state)
      R_IDLE: begin
        if (w_arfire) begin
          w_araddr_nxt  = S_AXI_ARADDR;
          w_arlen_nxt   = S_AXI_ARLEN;
          w_arsize_nxt  = S_AXI_ARSIZE;
          w_arburst_nxt = S_AXI_ARBURST;
          w_rbeat_nxt   = 8'd0;
          w_arready_nxt = 1'b0;
          w_rvalid_nxt  = 1'b1;
          w_rdata_nxt   = w_rl_data;
          w_rresp_nxt   = w_rl_ok ? RESP_OKAY : RESP_SLVERR;
          w_rlast_nxt   = (S_AXI_ARLEN == 8'd0);
          w_r_state_nxt = R_DATA;
        end else begin
          w_arready_nxt = 1'b1;
        end
      end
      R_DATA: begin
        if (w_rfire) begin
          if (r_rlast) begin
            w_rvalid_nxt  = 1'b0;
            w_rlast_nxt   = 1'b0;
            w_arready_nxt = 1'b1;
            w_r_state_nxt = R_IDLE;
          end else begin
            // Next beat is loaded on the accepting edge: no bubble.
            w_araddr_nxt  = w_ra_next;
            w_rbeat_nxt   = r_rbeat + 8'd1;
            w_rdata_nxt   = w_rl_data;
            w_rresp_nxt   = w_rl_ok ? RESP_OKAY : RESP_SLVERR;
            w_rlast_nxt   = ((r_rbeat + 8'd1) == r_arlen);
            w_r_state_nxt = R_DATA;
          end
        end else begin
          w_r_state_nxt = R_DATA;
        end
      end
      default: begin
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = 1'b0;
        w_rlast_nxt   = 1'b0;
        w_r_state_nxt = R_IDLE;
      end
    endcase
  end

  // Read FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r_state <= R_IDLE;
      r_araddr  <= {ADDR_WIDTH{1'b0}};
      r_arlen   <= 8'd0;
      r_arsize  <= 3'd0;
      r_arburst <= 2'b00;
      r_rbeat   <= 8'd0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= {DATA_WIDTH{1'b0}};
      r_rresp   <= 2'b00;
      r_rlast   <= 1'b0;
    end else begin
      r_r_state <= w_r_state_nxt;
      r_araddr  <= w_araddr_nxt;
      r_arlen   <= w_arlen_nxt;
      r_arsize  <= w_arsize_nxt;
      r_arburst <= w_arburst_nxt;
      r_rbeat   <= w_rbeat_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
      r_rlast   <= w_rlast_nxt;
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RLAST   = r_rlast;

endmodule

// File: tb/tb_axi4_burst_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_burst_sram_slave
//   Directed bench for axi4_burst_sram_slave. Bursts are driven through
//   write/read tasks; expected data are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_axi4_burst_sram_slave;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 1024;
  localparam logic [1:0]  OKAY  = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axi_awaddr = 32'd0;
  logic [7:0]  s_axi_awlen = 8'd0;
  logic [2:0]  s_axi_awsize = 3'd0;
  logic [1:0]  s_axi_awburst = 2'b00;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = 32'd0;
  logic [3:0]  s_axi_wstrb = 4'd0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [31:0] s_axi_araddr = 32'd0;
  logic [7:0]  s_axi_arlen = 8'd0;
  logic [2:0]  s_axi_arsize = 3'd0;
  logic [1:0]  s_axi_arburst = 2'b00;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;

  int          n_checks = 0;
  int          n_errs   = 0;

  logic [31:0] wr_data [32];
  logic [3:0]  wr_strb [32];
  logic [31:0] rd_data [32];
  logic [1:0]  rd_resp [32];
  logic        rd_last [32];
  logic [1:0]  last_bresp;

  axi4_burst_sram_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MEM_DEPTH  (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .S_AXI_AWADDR  (s_axi_awaddr),
    .S_AXI_AWLEN   (s_axi_awlen),
    .S_AXI_AWSIZE  (s_axi_awsize),
    .S_AXI_AWBURST (s_axi_awburst),
    .S_AXI_AWVALID (s_axi_awvalid),
    .S_AXI_AWREADY (s_axi_awready),
    .S_AXI_WDATA   (s_axi_wdata),
    .S_AXI_WSTRB   (s_axi_wstrb),
    .S_AXI_WLAST   (s_axi_wlast),
    .S_AXI_WVALID  (s_axi_wvalid),
    .S_AXI_WREADY  (s_axi_wready),
    .S_AXI_BRESP   (s_axi_bresp),
    .S_AXI_BVALID  (s_axi_bvalid),
    .S_AXI_BREADY  (s_axi_bready),
    .S_AXI_ARADDR  (s_axi_araddr),
    .S_AXI_ARLEN   (s_axi_arlen),
    .S_AXI_ARSIZE  (s_axi_arsize),
    .S_AXI_ARBURST (s_axi_arburst),
    .S_AXI_ARVALID (s_axi_arvalid),
    .S_AXI_ARREADY (s_axi_arready),
    .S_AXI_RDATA   (s_axi_rdata),
    .S_AXI_RRESP   (s_axi_rresp),
    .S_AXI_RLAST   (s_axi_rlast),
    .S_AXI_RVALID  (s_axi_rvalid),
    .S_AXI_RREADY  (s_axi_rready)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int bdelay);
    int n;
    s_axi_bready  = (bdelay == 0);
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awsize  = size;
    s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(posedge clk); #1; n++; end
    chk("aw_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wr_data[i];
      s_axi_wstrb  = wr_strb[i];
      s_axi_wlast  = (i == int'(len));
      n = 0;
      while (!s_axi_wready && n < 50) begin @(posedge clk); #1; n++; end
      chk("w_wait", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    chk("w_ready_drop", 32'(s_axi_wready), 32'd0);
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(posedge clk); #1; n++; end
    chk("b_wait", 32'(n < 50), 32'd1);
    last_bresp = s_axi_bresp;
    for (int i = 0; i < bdelay; i++) begin
      chk("b_hold_valid", 32'(s_axi_bvalid), 32'd1);
      chk("b_hold_awready", 32'(s_axi_awready), 32'd0);
      chk("b_hold_resp", 32'(s_axi_bresp), 32'(last_bresp));
      @(posedge clk); #1;
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    chk("b_done_valid", 32'(s_axi_bvalid), 32'd0);
    chk("b_done_awready", 32'(s_axi_awready), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input bit toggle);
    int          n;
    int          cyc;
    int          k;
    bit          stall;
    logic [31:0] hd;
    logic        hl;
    logic [1:0]  hr;
    hd = 32'd0;
    hl = 1'b0;
    hr = 2'b00;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = size;
    s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(posedge clk); #1; n++; end
    chk("ar_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    chk("r_first_valid", 32'(s_axi_rvalid), 32'd1);
    cyc   = 0;
    k     = 0;
    stall = 1'b0;
    while (k <= int'(len) && cyc < 600) begin
      s_axi_rready = toggle ? cyc[0] : 1'b1;
      if (s_axi_rvalid) begin
        if (stall) begin
          chk("r_stall_data", s_axi_rdata, hd);
          chk("r_stall_last", 32'(s_axi_rlast), 32'(hl));
          chk("r_stall_resp", 32'(s_axi_rresp), 32'(hr));
        end
        if (s_axi_rready) begin
          rd_data[k] = s_axi_rdata;
          rd_resp[k] = s_axi_rresp;
          rd_last[k] = s_axi_rlast;
          k++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          hd = s_axi_rdata;
          hl = s_axi_rlast;
          hr = s_axi_rresp;
        end
      end else begin
        stall = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_axi_rready = 1'b1;
    chk("r_all_beats", 32'(k), 32'(int'(len) + 1));
    chk("r_cycles", 32'(cyc), toggle ? 32'(2 * (int'(len) + 1)) : 32'(int'(len) + 1));
    chk("r_end_valid", 32'(s_axi_rvalid), 32'd0);
    chk("r_end_arready", 32'(s_axi_arready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      wr_data[i] = 32'd0;
      wr_strb[i] = 4'hF;
    end
    last_bresp = 2'b11;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_awready_pre", 32'(s_axi_awready), 32'd0);
    @(posedge clk); #1;
    chk("rel_awready", 32'(s_axi_awready), 32'd1);
    chk("rel_arready", 32'(s_axi_arready), 32'd1);

    // 1: INCR write then read back
    for (int i = 0; i < 4; i++) wr_data[i] = 32'h1111_1111 * 32'(i + 1);
    axi_write(BASE + 32'h10, 8'd3, 3'd2, 2'b01, 0);
    chk("t1_bresp", 32'(last_bresp), 32'(OKAY));
    axi_read(BASE + 32'h10, 8'd3, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rdata", rd_data[i], 32'h1111_1111 * 32'(i + 1));
      chk("t1_rresp", 32'(rd_resp[i]), 32'(OKAY));
      chk("t1_rlast", 32'(rd_last[i]), 32'(i == 3));
    end

    // 2: FIXED write leaves the last beat
    wr_data[0] = 32'hA; wr_data[1] = 32'hB; wr_data[2] = 32'hC; wr_data[3] = 32'hD;
    axi_write(BASE + 32'h20, 8'd3, 3'd2, 2'b00, 0);
    chk("t2_bresp", 32'(last_bresp), 32'(OKAY));
    axi_read(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 1'b0);
    chk("t2_rdata", rd_data[0], 32'h0000_000D);
    chk("t2_rlast", 32'(rd_last[0]), 32'd1);

    // 3: strobes, plus a narrow read returning the whole word
    wr_data[0] = 32'hFFFF_FFFF;
    axi_write(BASE + 32'h30, 8'd0, 3'd2, 2'b01, 0);
    wr_data[0] = 32'h1234_5678;
    wr_strb[0] = 4'b0101;
    axi_write(BASE + 32'h30, 8'd0, 3'd2, 2'b01, 0);
    wr_strb[0] = 4'hF;
    chk("t3_bresp", 32'(last_bresp), 32'(OKAY));
    axi_read(BASE + 32'h30, 8'd0, 3'd2, 2'b01, 1'b0);
    chk("t3_rdata", rd_data[0], 32'hFF34_FF78);
    axi_read(BASE + 32'h31, 8'd0, 3'd0, 2'b01, 1'b0);
    chk("t3_narrow", rd_data[0], 32'hFF34_FF78);

    // 4: window edge and burst-encoding errors
    wr_data[0] = 32'hCAFE_F00D; wr_data[1] = 32'hDEAD_BEEF;
    axi_write(BASE + 32'(DEPTH * 4) - 32'd4, 8'd1, 3'd2, 2'b01, 0);
    chk("t4_edge_bresp", 32'(last_bresp), 32'(SLVERR));
    axi_read(BASE + 32'(DEPTH * 4) - 32'd4, 8'd1, 3'd2, 2'b01, 1'b0);
    chk("t4_edge_d0", rd_data[0], 32'hCAFE_F00D);
    chk("t4_edge_r0", 32'(rd_resp[0]), 32'(OKAY));
    chk("t4_edge_d1", rd_data[1], 32'd0);
    chk("t4_edge_r1", 32'(rd_resp[1]), 32'(SLVERR));
    chk("t4_edge_l1", 32'(rd_last[1]), 32'd1);
    wr_data[0] = 32'h9999_9999;
    axi_write(BASE + 32'h10, 8'd0, 3'd2, 2'b10, 0);
    chk("t4_burst_bresp", 32'(last_bresp), 32'(SLVERR));
    axi_read(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    chk("t4_burst_nowr", rd_data[0], 32'h1111_1111);
    axi_read(BASE + 32'h10, 8'd1, 3'd2, 2'b11, 1'b0);
    chk("t4_arburst_d0", rd_data[0], 32'd0);
    chk("t4_arburst_r1", 32'(rd_resp[1]), 32'(SLVERR));
    axi_read(BASE + 32'h10, 8'd0, 3'd3, 2'b01, 1'b0);
    chk("t4_arsize_r", 32'(rd_resp[0]), 32'(SLVERR));
    axi_read(BASE - 32'd4, 8'd0, 3'd2, 2'b01, 1'b0);
    chk("t4_below_r", 32'(rd_resp[0]), 32'(SLVERR));

    // 5: backpressure on B and R
    for (int i = 0; i < 8; i++) wr_data[i] = 32'h5500_0000 + 32'(i);
    axi_write(BASE + 32'h100, 8'd7, 3'd2, 2'b01, 5);
    chk("t5_bresp", 32'(last_bresp), 32'(OKAY));
    axi_read(BASE + 32'h100, 8'd7, 3'd2, 2'b01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("t5_rdata", rd_data[i], 32'h5500_0000 + 32'(i));
      chk("t5_rlast", 32'(rd_last[i]), 32'(i == 7));
    end

    // 6a: concurrent 16-beat read and write on disjoint ranges
    for (int i = 0; i < 16; i++) wr_data[i] = 32'h3000_0000 + 32'(i);
    axi_write(BASE + 32'h300, 8'd15, 3'd2, 2'b01, 0);
    for (int i = 0; i < 16; i++) wr_data[i] = 32'hA000_0000 + 32'(i);
    fork
      axi_write(BASE + 32'h200, 8'd15, 3'd2, 2'b01, 0);
      axi_read(BASE + 32'h300, 8'd15, 3'd2, 2'b01, 1'b0);
    join
    chk("t6_bresp", 32'(last_bresp), 32'(OKAY));
    for (int i = 0; i < 16; i++) chk("t6_conc_rd", rd_data[i], 32'h3000_0000 + 32'(i));
    axi_read(BASE + 32'h200, 8'd15, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 16; i++) chk("t6_conc_wr", rd_data[i], 32'hA000_0000 + 32'(i));

    // 6b: reset in the middle of a write burst
    s_axi_awaddr  = BASE + 32'h400;
    s_axi_awlen   = 8'd7;
    s_axi_awsize  = 3'd2;
    s_axi_awburst = 2'b01;
    s_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    chk("t6r_wready", 32'(s_axi_wready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wstrb  = 4'hF;
      s_axi_wdata  = 32'h7700_0000 + 32'(i);
      s_axi_wlast  = 1'b0;
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6r_awready", 32'(s_axi_awready), 32'd0);
    chk("t6r_arready", 32'(s_axi_arready), 32'd0);
    chk("t6r_wready0", 32'(s_axi_wready), 32'd0);
    chk("t6r_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("t6r_bresp", 32'(s_axi_bresp), 32'd0);
    chk("t6r_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("t6r_rdata", s_axi_rdata, 32'd0);
    chk("t6r_rresp", 32'(s_axi_rresp), 32'd0);
    chk("t6r_rlast", 32'(s_axi_rlast), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("t6r_rel_pre", 32'(s_axi_awready), 32'd0);
    @(posedge clk); #1;
    chk("t6r_rel_aw", 32'(s_axi_awready), 32'd1);
    chk("t6r_rel_ar", 32'(s_axi_arready), 32'd1);
    wr_data[0] = 32'h8800_0000; wr_data[1] = 32'h8800_0001;
    axi_write(BASE + 32'h440, 8'd1, 3'd2, 2'b01, 0);
    chk("t6r_new_bresp", 32'(last_bresp), 32'(OKAY));
    axi_read(BASE + 32'h440, 8'd1, 3'd2, 2'b01, 1'b0);
    chk("t6r_new_d0", rd_data[0], 32'h8800_0000);
    chk("t6r_new_d1", rd_data[1], 32'h8800_0001);
    axi_read(BASE + 32'h400, 8'd2, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) chk("t6r_kept", rd_data[i], 32'h7700_0000 + 32'(i));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_burst_sram_slave.md
Name: axi4_burst_sram_slave

Overview:
- AXI4 subordinate (responder) fronting an on-chip word-addressed SRAM array; the target end of the DMA/CPU AXI4 master bursts.
- Accepts INCR and FIXED bursts of 1–256 beats, byte-strobed writes, and per-beat read responses.
- Out-of-window or unsupported accesses return SLVERR.
- Independent read and write FSMs; one outstanding transaction per direction.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, address bus width.
- MEM_DEPTH, 1024, number of 32-bit words in the array; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_DEPTH*4.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset (see Behaviour)
- S_AXI_AWADDR  in  ADDR_WIDTH  write burst start byte address
- S_AXI_AWLEN  in  8  beats-1
- S_AXI_AWSIZE  in  3  bytes/beat = 1<<SIZE
- S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10/11 unsupported
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4 / S_AXI_WLAST  in  1 / S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  ADDR_WIDTH / S_AXI_ARLEN  in  8 / S_AXI_ARSIZE  in  3 / S_AXI_ARBURST  in  2
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RLAST  out  1 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1

Behaviour:

Reset and clocking:
- Reset rst_n, asynchronous, active-low; clock clk.
- All outputs are registered and are 0 during reset (AWREADY, ARREADY, WREADY, BVALID, BRESP, RVALID, RDATA, RRESP, RLAST).
- The AWREADY and ARREADY outputs assert on the first clk edge after rst_n deasserts.
- Memory contents are not reset.
- Reset mid-burst aborts silently: FSMs return to IDLE, and beats already written stay written.

Address and response rules:
- Word index = (addr - BASE_ADDR) >> 2.
- A beat is in range iff BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*4.
- Address step per beat: INCR adds (1<<SIZE); FIXED holds the address.
- Address arithmetic is 32-bit; wrap at 2^32 is not special-cased, and the range check applies per beat.
- Burst-level error when BURST is 10/11 or SIZE > 2. In that case no memory access occurs for the whole burst, and every response is SLVERR.
- Response codes: OKAY = 00, SLVERR = 10.

Write FSM (W_IDLE → W_DATA → W_RESP):
- W_IDLE: AWREADY=1. On AWVALID&AWREADY: latch addr/len/size/burst, clear the beat counter and error flag, set AWREADY=0 and WREADY=1, go to W_DATA.
- W_DATA, each WVALID&WREADY beat:
  - If in range and there is no burst error, write byte lanes where WSTRB[i]=1 and leave the other lanes unchanged.
  - Otherwise set the error flag.
  - Advance the address and increment the beat counter.
  - Set the error flag if (beat == len) != WLAST.
- On the beat where beat == len, or where WLAST=1 (whichever comes first): WREADY=0, BVALID=1, BRESP = error ? SLVERR : OKAY, go to W_RESP.
- W_RESP: hold BVALID/BRESP stable until BREADY. On the handshake, BVALID=0, AWREADY=1, go to W_IDLE.
- Minimum cost is one cycle per beat plus 2 overhead cycles.

Read FSM (R_IDLE → R_DATA):
- R_IDLE: ARREADY=1. On ARVALID&ARREADY: latch the request, set ARREADY=0, go to R_DATA.
  - On the same edge, load RDATA from mem[word(ARADDR)], set RRESP, set RLAST = (ARLEN == 0), set RVALID=1.
  - First RVALID is therefore the cycle after the AR handshake.
- R_DATA: RDATA/RRESP/RLAST are held stable while RVALID & !RREADY.
- On RVALID&RREADY:
  - If the beat was last: RVALID=0, RLAST=0, ARREADY=1, go to R_IDLE.
  - Otherwise advance the address and load the next beat on the same edge, giving back-to-back beats with no bubble.
- Out-of-range or burst-error beat: RDATA=0, RRESP=SLVERR. The burst still completes with len+1 beats.
- Narrow reads (SIZE 0/1) return the full addressed word.

Read/write interaction:
- The FSMs run concurrently.
- A read load and a write to the same word on the same edge: the read returns the pre-write value.

Test Plan:
1. Write to BASE+0x10: AWLEN=3, INCR, SIZE=2, data 0x11111111..0x44444444, WSTRB=F, BREADY=1 → BRESP=OKAY. Then read AR BASE+0x10, ARLEN=3 → 4 beats 0x11111111..0x44444444, RLAST only on beat 4, RRESP=OKAY, no bubbles with RREADY=1.
2. FIXED write of 4 beats to BASE+0x20 (0xA, 0xB, 0xC, 0xD) → single-beat read of BASE+0x20 returns 0x0000000D.
3. Strobe test: word preloaded with 0xFFFFFFFF, write 0x12345678 with WSTRB=0101 → read returns 0xFF34FF78.
4. Range/error cases:
   - INCR 2-beat write starting at BASE+MEM_DEPTH*4-4 → beat 1 written, beat 2 dropped, BRESP=SLVERR.
   - Read of the same range → RRESP OKAY then SLVERR with RDATA=0.
   - AWBURST=10 → no memory writes, BRESP=SLVERR.
5. Backpressure: RREADY toggled 1/0 during an 8-beat read → RDATA/RLAST stable while stalled, all 8 values in order. BREADY held 0 for 5 cycles → BVALID held, AWREADY=0 until the handshake.
6. Concurrency/reset: concurrent 16-beat read and 16-beat write to disjoint ranges → both complete correctly. rst_n pulsed mid-write-burst → all outputs 0, AWREADY/ARREADY=1 one edge after release, and a new burst completes OKAY.
